// File: rtl/qenc_dqp_bin_fsm.sv
// rtl/qenc_dqp_bin_fsm.sv - delta-QP binarizer (TU prefix + EG0 suffix + sign) feeding the CABAC bin encoder
module qenc_dqp_bin_fsm #(
    parameter logic [9:0] CTX_ADDR_ABS0 = 10'd0,
    parameter logic [9:0] CTX_ADDR_ABS1 = 10'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dqp_start,
    input  logic       cu_qp_delta_enabled_flag,
    input  logic [6:0] cu_qp_delta_val,
    output logic       busy,
    output logic       bin_vld,
    input  logic       bin_rdy,
    output logic       bin_val,
    output logic       bin_bypass,
    output logic [9:0] bin_ctx_addr,
    output logic       dqp_done_intr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_PREFIX,
        S_EG_PREFIX,
        S_EG_SUFFIX,
        S_SIGN,
        S_ENDING
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] abs_q, abs_d;
    logic [6:0] rem_q, rem_d;
    logic       sign_q, sign_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] k_q, k_d;
    logic       done_q;
    logic [6:0] val_abs;
    logic [6:0] eg_step;
    logic       xfer;

    // -64 maps to 64, which still fits the 7-bit unsigned magnitude
    assign val_abs = cu_qp_delta_val[6] ? (~cu_qp_delta_val + 7'd1) : cu_qp_delta_val;
    assign eg_step = 7'd1 << k_q;
    assign busy          = (state_q != S_IDLE);
    assign dqp_done_intr = done_q;

    // State, captured operands and counters; done is a registered copy of ENDING
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            abs_q   <= 7'd0;
            rem_q   <= 7'd0;
            sign_q  <= 1'b0;
            idx_q   <= 3'd0;
            k_q     <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            abs_q   <= abs_d;
            rem_q   <= rem_d;
            sign_q  <= sign_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            done_q  <= (state_q == S_ENDING);
        end
    end

    // Bin fields come from registers only; bin_rdy steers just the next-state terms
    always_comb begin
        state_d      = state_q;
        abs_d        = abs_q;
        rem_d        = rem_q;
        sign_d       = sign_q;
        idx_d        = idx_q;
        k_d          = k_q;
        bin_vld      = 1'b0;
        bin_val      = 1'b0;
        bin_bypass   = 1'b0;
        bin_ctx_addr = 10'd0;
        xfer         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dqp_start) begin
                    abs_d   = val_abs;
                    sign_d  = cu_qp_delta_val[6];
                    rem_d   = (val_abs >= 7'd5) ? (val_abs - 7'd5) : 7'd0;
                    idx_d   = 3'd0;
                    k_d     = 3'd0;
                    state_d = cu_qp_delta_enabled_flag ? S_ABS_PREFIX : S_ENDING;
                end
            end
            S_ABS_PREFIX: begin
                bin_vld      = 1'b1;
                bin_val      = ({4'd0, idx_q} < abs_q);
                bin_ctx_addr = (idx_q == 3'd0) ? CTX_ADDR_ABS0 : CTX_ADDR_ABS1;
                xfer         = bin_rdy;
                if (xfer) begin
                    if (!bin_val) begin
                        state_d = (abs_q == 7'd0) ? S_ENDING : S_SIGN;
                    end else if (idx_q == 3'd4) begin
                        state_d = S_EG_PREFIX;
                        k_d     = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_EG_PREFIX: begin
                bin_vld    = 1'b1;
                bin_bypass = 1'b1;
                bin_val    = (rem_q >= eg_step);
                xfer       = bin_rdy;
                if (xfer) begin
                    if (bin_val) begin
                        rem_d = rem_q - eg_step;
                        k_d   = k_q + 3'd1;
                    end else begin
                        state_d = (k_q != 3'd0) ? S_EG_SUFFIX : S_SIGN;
                    end
                end
            end
            S_EG_SUFFIX: begin
                bin_vld    = 1'b1;
                bin_bypass = 1'b1;
                bin_val    = rem_q[k_q - 3'd1];
                xfer       = bin_rdy;
                if (xfer) begin
                    k_d = k_q - 3'd1;
                    if (k_q == 3'd1) begin
                        state_d = S_SIGN;
                    end
                end
            end
            S_SIGN: begin
                bin_vld    = 1'b1;
                bin_bypass = 1'b1;
                bin_val    = sign_q;
                xfer       = bin_rdy;
                if (xfer) begin
                    state_d = S_ENDING;
                end
            end
            S_ENDING: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_qenc_dqp_bin_fsm.sv
// tb/tb_qenc_dqp_bin_fsm.sv - randomized self-checking bench for qenc_dqp_bin_fsm
module tb_qenc_dqp_bin_fsm;

    localparam logic [9:0] A0 = 10'd37;
    localparam logic [9:0] A1 = 10'd38;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dqp_start = 1'b0;
    logic       cu_qp_delta_enabled_flag = 1'b0;
    logic [6:0] cu_qp_delta_val = 7'd0;
    logic       busy;
    logic       bin_vld;
    logic       bin_rdy = 1'b0;
    logic       bin_val;
    logic       bin_bypass;
    logic [9:0] bin_ctx_addr;
    logic       dqp_done_intr;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    qenc_dqp_bin_fsm #(
        .CTX_ADDR_ABS0(A0),
        .CTX_ADDR_ABS1(A1)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .dqp_start               (dqp_start),
        .cu_qp_delta_enabled_flag(cu_qp_delta_enabled_flag),
        .cu_qp_delta_val         (cu_qp_delta_val),
        .busy                    (busy),
        .bin_vld                 (bin_vld),
        .bin_rdy                 (bin_rdy),
        .bin_val                 (bin_val),
        .bin_bypass              (bin_bypass),
        .bin_ctx_addr            (bin_ctx_addr),
        .dqp_done_intr           (dqp_done_intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ent(input int b, input int byp, input int ctx);
        return (b * 2048) + (byp * 1024) + ctx;
    endfunction

    function automatic int fields();
        logic [11:0] f;
        f = {bin_val, bin_bypass, bin_ctx_addr};
        return int'(f);
    endfunction

    // Reference bin list: truncated unary (cMax 5), then 0th-order Exp-Golomb of abs-5, then sign
    task automatic build(input int v, input bit en);
        int a, r, n, s;
        exp_q.delete();
        if (en) begin
            a = (v < 0) ? -v : v;
            for (int i = 0; i < 5; i++) begin
                exp_q.push_back(ent((i < a) ? 1 : 0, 0, (i == 0) ? int'(A0) : int'(A1)));
                if (i >= a) break;
            end
            if (a >= 5) begin
                r = a - 5;
                n = 0;
                while (((r + 1) >> (n + 1)) != 0) n++;
                for (int i = 0; i < n; i++) exp_q.push_back(ent(1, 1, 0));
                exp_q.push_back(ent(0, 1, 0));
                s = r + 1 - (1 << n);
                for (int i = n - 1; i >= 0; i--) exp_q.push_back(ent((s >> i) & 1, 1, 0));
            end
            if (a > 0) exp_q.push_back(ent((v < 0) ? 1 : 0, 1, 0));
        end
    endtask

    task automatic run_seq(input int v, input bit en, input bit rnd);
        int cyc, last_x, nx, busy_cnt, exp_n, pf;
        bit done_seen, pv, pr;
        build(v, en);
        exp_n = exp_q.size();
        @(posedge clk); #1;
        dqp_start = 1'b1;
        cu_qp_delta_val = v[6:0];
        cu_qp_delta_enabled_flag = en;
        bin_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        check("busy_at_start", int'(busy), 0);
        @(posedge clk); #1;
        dqp_start = 1'b0;
        cu_qp_delta_val = 7'($urandom);
        cu_qp_delta_enabled_flag = 1'($urandom);
        bin_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc = 1; last_x = 0; nx = 0; busy_cnt = 0; done_seen = 0; pv = 0; pr = 0; pf = 0;
        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            if (cyc == 1) check($sformatf("first_vld v=%0d", v), int'(bin_vld), int'(en));
            if (pv && !pr) begin
                check("stall_vld", int'(bin_vld), 1);
                check("stall_fields", fields(), pf);
            end
            busy_cnt += int'(busy);
            if (dqp_done_intr) begin
                done_seen = 1;
                check($sformatf("done_cyc v=%0d", v), cyc, en ? last_x + 2 : 2);
            end
            if (bin_vld && bin_rdy) begin
                if (exp_q.size() == 0) check("extra_bin", fields(), -1);
                else check($sformatf("bin%0d v=%0d", nx, v), fields(), exp_q.pop_front());
                nx++;
                last_x = cyc;
            end
            pv = bin_vld; pr = bin_rdy; pf = fields();
            if (!done_seen) begin
                @(posedge clk); #1;
                bin_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                dqp_start = (rnd && pv) ? 1'($urandom_range(0, 1)) : 1'b0;
                cu_qp_delta_val = 7'($urandom);
                cyc++;
            end
        end
        if (!done_seen) check("timeout", 0, 1);
        check($sformatf("n_bins v=%0d", v), nx, exp_n);
        check("busy_cycles", busy_cnt, done_seen ? cyc - 1 : -1);
        @(posedge clk); #1;
        dqp_start = 1'b0;
        @(negedge clk);
        check("done_pulse_width", int'(dqp_done_intr), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        repeat (3) @(negedge clk);
        check("rst_fields", fields(), 0);
        check("rst_vld_busy_done", int'({bin_vld, busy, dqp_done_intr}), 0);
        rst = 1'b0;

        run_seq(17, 1'b0, 1'b0);
        run_seq(0, 1'b1, 1'b0);
        run_seq(-3, 1'b1, 1'b0);
        run_seq(5, 1'b1, 1'b0);
        run_seq(7, 1'b1, 1'b1);
        run_seq(-64, 1'b1, 1'b1);
        run_seq(63, 1'b1, 1'b1);

        // abort a -64 stream inside the Exp-Golomb prefix
        @(posedge clk); #1;
        dqp_start = 1'b1; cu_qp_delta_val = 7'h40; cu_qp_delta_enabled_flag = 1'b1; bin_rdy = 1'b1;
        @(posedge clk); #1;
        dqp_start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("pre_rst_bypass", int'(bin_bypass), 1);
        rst = 1'b1;
        #1;
        check("async_rst_fields", fields(), 0);
        check("async_rst_vld_busy_done", int'({bin_vld, busy, dqp_done_intr}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_seq(1, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 127)) - 64;
            run_seq(v, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qenc_dqp_bin_fsm.md
Name: qenc_dqp_bin_fsm

Overview:
Encoder-side delta-QP binarizer. It converts one signed CuQpDeltaVal into the ordered bin stream for cu_qp_delta_abs and cu_qp_delta_sign_flag:
- TU prefix with cMax=5, context coded.
- EG0 suffix in bypass mode.
- Sign bin in bypass mode.

Bins go to the CABAC bin encoder over a valid/ready handshake. The block is a sub-FSM started by the transform-unit encode FSM, and it returns a one-cycle done interrupt.

Parameters:
CTX_ADDR_ABS0, 10'd0, context memory address for bin 0 of cu_qp_delta_abs (integrator sets it to the package CTXIDX value)
CTX_ADDR_ABS1, 10'd1, context memory address for prefix bins 1..4

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
dqp_start  input  1  one-cycle start pulse; sampled only in IDLE
cu_qp_delta_enabled_flag  input  1  when 0, the block emits no bins and only signals done
cu_qp_delta_val  input  7  signed two's complement, range -64..+63; captured on accepted dqp_start
busy  output  1  high whenever state != IDLE
bin_vld  output  1  a bin is presented to the bin encoder
bin_rdy  input  1  the bin encoder accepts the bin; a transfer occurs when bin_vld && bin_rdy
bin_val  output  1  bin value
bin_bypass  output  1  1 = bypass (EP) bin, 0 = context-coded bin
bin_ctx_addr  output  10  context address; 0 when bin_bypass=1
dqp_done_intr  output  1  one-cycle pulse on completion

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - state = IDLE; all counters and captured values = 0.
  - bin_vld, bin_val, bin_bypass, bin_ctx_addr, busy, dqp_done_intr = 0.
  - After reset is released, no partial stream resumes.
- Capture on dqp_start in IDLE:
  - abs = |val| as 7-bit unsigned (-64 gives 64).
  - sign = val[6].
  - rem = abs-5 when abs >= 5.
  - dqp_start while busy is ignored. Later changes to cu_qp_delta_val are ignored.
- States: IDLE, ABS_PREFIX, EG_PREFIX, EG_SUFFIX, SIGN, ENDING.
  - IDLE -> ABS_PREFIX on dqp_start with enabled=1.
  - IDLE -> ENDING on dqp_start with enabled=0.
- bin_vld and all bin fields are decoded from registered state and counters only. There is no combinational path from bin_rdy to any output.
  - bin_vld=1 in ABS_PREFIX, EG_PREFIX, EG_SUFFIX and SIGN.
  - Fields hold stable while bin_vld && !bin_rdy.
  - The first bin_vld appears the cycle after dqp_start. With bin_rdy held high, one bin transfers per cycle with no bubbles.
- ABS_PREFIX: index i = 0..4.
  - bin_val = (i < abs); bin_bypass = 0.
  - bin_ctx_addr = (i == 0) ? CTX_ADDR_ABS0 : CTX_ADDR_ABS1.
  - The state ends after the transfer of the 0 bin (abs < 5) or of the 5th bin (abs >= 5).
  - Exit to ENDING if abs == 0; to EG_PREFIX if abs >= 5; otherwise to SIGN.
- EG_PREFIX: k starts at 0; all bins bypass.
  - If rem >= (1<<k): emit 1; on transfer, rem -= 1<<k and k++.
  - Otherwise emit 0; on transfer, go to EG_SUFFIX if k > 0, else to SIGN.
  - k never exceeds 5 given the input range.
- EG_SUFFIX: emit rem[k-1], MSB first, bypass; decrement k on each transfer. Go to SIGN after the transfer with k == 1.
- SIGN: emit sign, bypass (1 = negative); go to ENDING on transfer. This state is never entered when abs == 0.
- ENDING: lasts one cycle with bin_vld=0, then IDLE.
- dqp_done_intr is registered (state == ENDING), so it is high the cycle after ENDING.
  - enabled=0: dqp_start at cycle 0 gives done at cycle 2.
  - Otherwise: last transfer at cycle N gives done at cycle N+2.
- A new dqp_start is accepted in the same cycle dqp_done_intr is high, because state is already IDLE.
- Backpressure: bin_rdy low for any number of cycles stalls the state and counters with no bin lost or duplicated.

Test Plan:
- enabled=0, dqp_start -> zero bin transfers; busy high for 1 cycle; dqp_done_intr high exactly 2 cycles after start.
- val=0, bin_rdy=1 -> one bin: 0, ctx=CTX_ADDR_ABS0, bypass=0; done at last transfer +2.
- val=-3 -> bins 1,1,1,0 (ctx ABS0, ABS1, ABS1, ABS1; bypass=0), then sign 1 (bypass); 5 transfers total.
- val=+5 -> 1,1,1,1,1 (context coded), then 0 (EG prefix, bypass), then sign 0; 7 transfers.
- val=+7 and val=-64, with bin_rdy toggling randomly 50% of cycles:
  - +7 -> 1,1,1,1,1,1,0,1,0.
  - -64 -> 1,1,1,1,1, 1,1,1,1,1,0, 1,1,1,0,0, 1 (17 bins).
  - Fields stable while stalled.
- Assert rst mid-EG_PREFIX -> all outputs 0 immediately. After release, a new dqp_start with val=+1 yields exactly 1,0,0 with no residue from the aborted stream.
